// File: rtl/stopwatch_core.sv
//==============================================================================
// stopwatch_core : MM:SS BCD stopwatch clocked by clk_in, advanced by a synchronized tick_in
// Optional lap/shadow display enabled by STOPWATCH_LAP_EN.  Rev 1.0
//==============================================================================
`default_nettype none

module stopwatch_core #(
  parameter int TICKS_PER_SEC = 1,
  parameter int MAX_MIN       = 59
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       clear_btn,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap_btn,
  output logic       lap_active,
`endif
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       rollover
);

  localparam logic [7:0] PRESC_LAST   = 8'(TICKS_PER_SEC - 1);
  localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t     state;
  logic       s1, s2, s3;
  logic       tick_evt;
  logic [7:0] presc;
  logic [3:0] cnt_so, cnt_st, cnt_mo, cnt_mt;
  logic [3:0] nxt_so, nxt_st, nxt_mo, nxt_mt;
  logic       at_max;

  assign tick_evt = s2 & ~s3;

  // One-second BCD increment; the MAX_MIN:59 case wraps the whole display.
  always_comb begin
    nxt_so = cnt_so + 4'd1;
    nxt_st = cnt_st;
    nxt_mo = cnt_mo;
    nxt_mt = cnt_mt;
    at_max = 1'b0;
    if (cnt_mt == MAX_MIN_TENS && cnt_mo == MAX_MIN_ONES &&
        cnt_st == 4'd5 && cnt_so == 4'd9) begin
      nxt_so = 4'd0;
      nxt_st = 4'd0;
      nxt_mo = 4'd0;
      nxt_mt = 4'd0;
      at_max = 1'b1;
    end else if (cnt_so == 4'd9) begin
      nxt_so = 4'd0;
      if (cnt_st == 4'd5) begin
        nxt_st = 4'd0;
        if (cnt_mo == 4'd9) begin
          nxt_mo = 4'd0;
          nxt_mt = cnt_mt + 4'd1;
        end else begin
          nxt_mo = cnt_mo + 4'd1;
        end
      end else begin
        nxt_st = cnt_st + 4'd1;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [15:0] shadow;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      presc    <= 8'd0;
      cnt_so   <= 4'd0;
      cnt_st   <= 4'd0;
      cnt_mo   <= 4'd0;
      cnt_mt   <= 4'd0;
      running  <= 1'b0;
      rollover <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_active <= 1'b0;
      shadow     <= 16'd0;
`endif
    end else begin
      s1       <= tick_in;
      s2       <= s1;
      s3       <= s2;
      rollover <= 1'b0;
      if (clear_btn) begin
        state   <= IDLE;
        presc   <= 8'd0;
        cnt_so  <= 4'd0;
        cnt_st  <= 4'd0;
        cnt_mo  <= 4'd0;
        cnt_mt  <= 4'd0;
        running <= 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap_active <= 1'b0;
`endif
      end else begin
        // Counting looks at the pre-edge state, so a tick alongside stop still lands.
        if (state == RUN && tick_evt) begin
          if (presc == PRESC_LAST) begin
            presc    <= 8'd0;
            cnt_so   <= nxt_so;
            cnt_st   <= nxt_st;
            cnt_mo   <= nxt_mo;
            cnt_mt   <= nxt_mt;
            rollover <= at_max;
          end else begin
            presc <= presc + 8'd1;
          end
        end
        case (state)
          RUN: begin
            if (stop_btn) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
          IDLE, PAUSE: begin
            if (start_btn && !stop_btn) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
`ifdef STOPWATCH_LAP_EN
        if (state == RUN && lap_btn) begin
          lap_active <= ~lap_active;
          if (!lap_active) shadow <= {cnt_mt, cnt_mo, cnt_st, cnt_so};
        end
`endif
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  assign sec_ones = lap_active ? shadow[3:0]   : cnt_so;
  assign sec_tens = lap_active ? shadow[7:4]   : cnt_st;
  assign min_ones = lap_active ? shadow[11:8]  : cnt_mo;
  assign min_tens = lap_active ? shadow[15:12] : cnt_mt;
`else
  assign sec_ones = cnt_so;
  assign sec_tens = cnt_st;
  assign min_ones = cnt_mo;
  assign min_tens = cnt_mt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_core.sv
//==============================================================================
// tb_stopwatch_core : directed self-checking bench for stopwatch_core
// Covers lap display when STOPWATCH_LAP_EN is defined.  Rev 1.0
//==============================================================================
`default_nettype none

module tb_stopwatch_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_in = 1'b0, start_btn = 1'b0, stop_btn = 1'b0, clear_btn = 1'b0;
  logic tick4 = 1'b0, start4 = 1'b0, stop4 = 1'b0, clear4 = 1'b0;
  logic [3:0] so, st, mo, mt, so4, st4, mo4, mt4;
  logic run, roll, run4, roll4;
`ifdef STOPWATCH_LAP_EN
  logic lap_btn = 1'b0;
  logic lap, lap4;
`endif

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stopwatch_core #(.TICKS_PER_SEC(1), .MAX_MIN(2)) dut (
    .clk_in(clk), .rst_n(rst_n), .tick_in(tick_in),
    .start_btn(start_btn), .stop_btn(stop_btn), .clear_btn(clear_btn),
`ifdef STOPWATCH_LAP_EN
    .lap_btn(lap_btn), .lap_active(lap),
`endif
    .sec_ones(so), .sec_tens(st), .min_ones(mo), .min_tens(mt),
    .running(run), .rollover(roll)
  );

  stopwatch_core #(.TICKS_PER_SEC(4), .MAX_MIN(59)) dut4 (
    .clk_in(clk), .rst_n(rst_n), .tick_in(tick4),
    .start_btn(start4), .stop_btn(stop4), .clear_btn(clear4),
`ifdef STOPWATCH_LAP_EN
    .lap_btn(1'b0), .lap_active(lap4),
`endif
    .sec_ones(so4), .sec_tens(st4), .min_ones(mo4), .min_tens(mt4),
    .running(run4), .rollover(roll4)
  );

  wire [15:0] t1 = {mt, mo, st, so};
  wire [15:0] t4 = {mt4, mo4, st4, so4};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance n clock edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick_in = 1'b1; step(3);
    tick_in = 1'b0; step(3);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic ticks4(input int n);
    for (int i = 0; i < n; i++) begin
      tick4 = 1'b1; step(3);
      tick4 = 1'b0; step(3);
    end
  endtask

  initial begin
    #2;
    check("reset_digits", t1, 16'h0000);
    check("reset_running", {15'd0, run}, 16'd0);
    check("reset_rollover", {15'd0, roll}, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    step(2);

    start_btn = 1'b1; step(1); start_btn = 1'b0;
    check("start_running", {15'd0, run}, 16'd1);

    // First tick: update lands exactly two edges after the first high sample.
    tick_in = 1'b1; step(1);
    check("lat_edge_n", t1, 16'h0000);
    step(1);
    check("lat_edge_n1", t1, 16'h0000);
    step(1);
    check("lat_edge_n2", t1, 16'h0001);
    tick_in = 1'b0; step(3);
    ticks(11);
    check("twelve_ticks", t1, 16'h0012);
    check("twelve_running", {15'd0, run}, 16'd1);

    ticks(47);
    check("at_0059", t1, 16'h0059);
    do_tick();
    check("min_carry", t1, 16'h0100);
    ticks(119);
    check("at_0259", t1, 16'h0259);

    tick_in = 1'b1; step(2);
    check("roll_before", {15'd0, roll}, 16'd0);
    step(1);
    check("roll_digits", t1, 16'h0000);
    check("roll_pulse", {15'd0, roll}, 16'd1);
    step(1);
    check("roll_one_cycle", {15'd0, roll}, 16'd0);
    check("roll_still_run", {15'd0, run}, 16'd1);
    tick_in = 1'b0; step(2);

    // Stop on the same edge as a tick event: the tick still counts.
    tick_in = 1'b1; step(2);
    stop_btn = 1'b1; step(1); stop_btn = 1'b0;
    check("stop_tick_counts", t1, 16'h0001);
    check("stop_running", {15'd0, run}, 16'd0);
    tick_in = 1'b0; step(3);
    ticks(5);
    check("pause_holds", t1, 16'h0001);
    start_btn = 1'b1; step(1); start_btn = 1'b0;
    check("resume_running", {15'd0, run}, 16'd1);
    do_tick();
    check("resume_count", t1, 16'h0002);
    ticks(5);
    check("at_0007", t1, 16'h0007);

    stop_btn = 1'b1; step(1); stop_btn = 1'b0;
    start_btn = 1'b1; stop_btn = 1'b1; step(1);
    start_btn = 1'b0; stop_btn = 1'b0;
    check("both_in_pause", {15'd0, run}, 16'd0);
    do_tick();
    check("both_pause_holds", t1, 16'h0007);
    start_btn = 1'b1; step(1); start_btn = 1'b0;

    tick_in = 1'b1; step(2);
    clear_btn = 1'b1; step(1); clear_btn = 1'b0;
    check("clear_digits", t1, 16'h0000);
    check("clear_running", {15'd0, run}, 16'd0);
    tick_in = 1'b0; step(3);
    do_tick();
    check("idle_discards", t1, 16'h0000);

    // Start alongside a tick event from IDLE: that tick is dropped.
    tick_in = 1'b1; step(2);
    start_btn = 1'b1; step(1); start_btn = 1'b0;
    check("start_tick_digits", t1, 16'h0000);
    check("start_tick_running", {15'd0, run}, 16'd1);
    tick_in = 1'b0; step(3);
    do_tick();
    check("after_start_tick", t1, 16'h0001);

`ifdef STOPWATCH_LAP_EN
    ticks(4);
    check("lap_pre", t1, 16'h0005);
    lap_btn = 1'b1; step(1); lap_btn = 1'b0;
    check("lap_on", {15'd0, lap}, 16'd1);
    ticks(4);
    check("lap_frozen", t1, 16'h0005);
    lap_btn = 1'b1; step(1); lap_btn = 1'b0;
    check("lap_off", {15'd0, lap}, 16'd0);
    check("lap_live", t1, 16'h0009);
    lap_btn = 1'b1; step(1); lap_btn = 1'b0;
    check("lap_on_again", {15'd0, lap}, 16'd1);
`endif

    // Asynchronous reset mid-count, asserted between clock edges.
    tick_in = 1'b1; step(2);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_digits", t1, 16'h0000);
    check("async_rst_running", {15'd0, run}, 16'd0);
`ifdef STOPWATCH_LAP_EN
    check("async_rst_lap", {15'd0, lap}, 16'd0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    step(4);
    start_btn = 1'b1; step(1); start_btn = 1'b0;
    tick_in = 1'b0; step(3);
    check("held_tick_no_count", t1, 16'h0000);
    do_tick();
    check("post_rst_tick", t1, 16'h0001);

    // Prescaled instance, four ticks per second.
    start4 = 1'b1; step(1); start4 = 1'b0;
    check("p4_running", {15'd0, run4}, 16'd1);
    ticks4(3);
    check("p4_three", t4, 16'h0000);
    ticks4(1);
    check("p4_four", t4, 16'h0001);
    ticks4(3);
    check("p4_seven", t4, 16'h0001);
    stop4 = 1'b1; step(1); stop4 = 1'b0;
    ticks4(3);
    check("p4_paused", t4, 16'h0001);
    start4 = 1'b1; step(1); start4 = 1'b0;
    ticks4(1);
    check("p4_resume", t4, 16'h0002);
    clear4 = 1'b1; step(1); clear4 = 1'b0;
    check("p4_clear", t4, 16'h0000);
    check("p4_clear_run", {15'd0, run4}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Downstream consumer of the divided clock: treats the divider's slow square wave as a data signal in the clk_in domain, never as a clock.
- Synchronizes that signal, detects its rising edges, and runs an MM:SS BCD stopwatch with start/stop/clear control.
- Drives the display/segment stage of the final project.

Parameters:
- TICKS_PER_SEC, 1, rising edges of tick_in per one-second increment; legal 1..255.
- MAX_MIN, 59, highest minute value before wrap; legal 0..99.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_n  input  1  asynchronous reset, active-low.
- tick_in  input  1  divided clock from the divider stage; asynchronous to this logic's sampling.
- start_btn  input  1  single-cycle start/resume pulse.
- stop_btn  input  1  single-cycle pause pulse.
- clear_btn  input  1  single-cycle clear pulse.
- sec_ones  output  4  BCD seconds units.
- sec_tens  output  4  BCD seconds tens.
- min_ones  output  4  BCD minutes units.
- min_tens  output  4  BCD minutes tens.
- running  output  1  high while in RUN.
- rollover  output  1  one-cycle pulse on MAX_MIN:59 -> 00:00.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_n is asynchronous and active-low.
- Reset values: all digits 0, running 0, rollover 0, state IDLE, prescaler 0, synchronizer flops 0.
- Synchronizer: 2-flop synchronizer s1/s2, plus a history flop s3.
- Edge detect: tick_evt = s2 & ~s3.
- Latency: if tick_in is first sampled high at edge N, tick_evt is high during cycle N+1 to N+2. Digits update at edge N+2.
- States: IDLE (zeroed, stopped), RUN, PAUSE.
- Transitions, evaluated at each edge in priority order:
  - clear_btn: -> IDLE, digits 0, prescaler 0, from any state.
  - stop_btn in RUN: -> PAUSE.
  - start_btn in IDLE or PAUSE: -> RUN.
  - start_btn in RUN and stop_btn outside RUN are ignored.
  - start_btn and stop_btn together: stop wins (RUN -> PAUSE; IDLE/PAUSE unchanged).
- Counting uses the state before the edge:
  - tick_evt while in RUN advances the prescaler; counts coinciding with stop_btn are kept.
  - tick_evt in IDLE or PAUSE is discarded, including a tick coinciding with start_btn in IDLE.
  - clear_btn discards a coincident tick.
- Prescaler: counts 0..TICKS_PER_SEC-1. On its terminal count it wraps to 0 and the time advances by one second. It is held (not reset) in PAUSE.
- BCD increment:
  - sec_ones 9 -> 0 with carry to sec_tens.
  - sec_tens 5 -> 0 with carry to minutes.
  - min_ones 9 -> 0 with carry to min_tens.
  - At MAX_MIN:59 the increment yields 00:00, rollover pulses high for exactly that cycle, and counting continues in RUN.
- Digit invariant: digits never take values above 9, sec_tens never above 5.
- Output timing: running is registered; it goes high the cycle after the start edge and low the cycle after the stop or clear edge.
- Reset mid-count: reset asserted at any time forces all reset values immediately, independent of clk_in. The first tick after release counts only if tick_in is seen to go low and then rise again (s3 is reset to 0, so a tick_in already high at release produces one event).

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- With the macro defined:
  - Adds input lap_btn (1 bit) and output lap_active (1 bit).
  - lap_btn in RUN toggles lap_active. On the 0->1 toggle, the current digits are captured into a shadow register.
  - While lap_active=1, the digit outputs show the shadow value and the internal count keeps running.
  - lap_btn outside RUN is ignored.
  - clear_btn and reset clear lap_active.
  - stop_btn does not clear lap_active.
- Without the macro: no lap ports, no shadow register, and digit outputs always show the live count.

Test Plan:
- Reset, start_btn, tick_in toggling with TICKS_PER_SEC=1, 12 rising edges -> digits 00:12, running=1, each update exactly 2 clk_in cycles after the first high sample.
- Preload 00:59 via ticks, one more tick -> 01:00. Run to MAX_MIN=2 at 02:59, one tick -> 00:00, rollover high for exactly 1 cycle.
- RUN, stop_btn with a coincident tick_evt -> that tick counts, then PAUSE. Five further ticks -> digits unchanged. start_btn -> resumes from the same value.
- start_btn and stop_btn in the same cycle from PAUSE -> stays PAUSE. clear_btn with a coincident tick at 00:07 -> 00:00, IDLE, running=0.
- TICKS_PER_SEC=4: 7 ticks -> 00:01 with prescaler=3. Pause, 3 ticks, resume, 1 tick -> 00:02.
- STOPWATCH_LAP_EN: lap at 00:05, 4 ticks -> outputs still 00:05. Second lap_btn -> outputs 00:09. rst_n low mid-count -> all zero asynchronously.
